// File: rtl/spi_reg_pkg.sv
// Shared constants, state encoding and frame builder for the SPI register master.
// The frame is {rw, addr[6:0], data[7:0]} and is shifted out MSB first.
package spi_reg_pkg;

   localparam int RW_BIT     = 7;
   localparam int FRAME_BITS = 16;

   localparam logic [6:0] REG_FPGA_FW_VERSION = 7'h00;
   localparam logic [6:0] REG_AEROFC_FORCE_BT = 7'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   // Reads always carry 0x00 in the data byte, whatever wdata holds.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic       wr,
                                                         input logic [6:0] addr,
                                                         input logic [7:0] wdata);
      logic [7:0] b0;
      b0         = 8'h00;
      b0[6:0]    = addr;
      b0[RW_BIT] = wr;
      return {b0, (wr ? wdata : 8'h00)};
   endfunction

endpackage

// File: rtl/spi_half_period_tick.sv
// Free-running CLK_DIV down-counter; tick marks the last cycle of each SCLK half-period.
// restart realigns the count so the first half-period after a command is full length.
module spi_half_period_tick #(
   parameter int CLK_DIV = 25
) (
   input  logic clk_core,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int            CW     = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_half_period_tick: CLK_DIV must be at least 2");
   end

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (restart || (cnt_q == '0)) begin
         cnt_d = RELOAD;
      end
   end

   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_reg_master.sv
// Mode-0 SPI master issuing one 2-byte register read/write per accepted command.
// Phases SETUP, 16 x (high, low), HOLD and GAP each last one CLK_DIV half-period.
module spi_reg_master
   import spi_reg_pkg::*;
#(
   parameter int CLK_DIV = 25
) (
   input  logic       clk_core,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       busy,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_ss
);

   state_t                  state_q, state_d;
   logic [FRAME_BITS-1:0]   tx_q, tx_d;
   logic [7:0]              rx_q, rx_d;
   logic [3:0]              bit_q, bit_d;
   logic                    high_q, high_d;
   logic                    sclk_q, sclk_d;
   logic                    ss_q, ss_d;
   logic                    mosi_q, mosi_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [7:0]              rdata_q, rdata_d;
   logic                    ready_q, ready_d;
   logic                    busy_q, busy_d;
   logic                    miso_q;
   logic                    accept;
   logic                    tick;
   logic [FRAME_BITS-1:0]   frame;

   assign accept = (state_q == ST_IDLE) && cmd_valid;
   assign frame  = build_frame(cmd_write, cmd_addr, cmd_wdata);

   spi_half_period_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_core (clk_core),
      .reset_n  (reset_n),
      .restart  (accept),
      .tick     (tick)
   );

   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_d       = bit_q;
      high_d      = high_q;
      sclk_d      = sclk_q;
      ss_d        = ss_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rdata_d     = rdata_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
               tx_d    = frame;
               mosi_d  = frame[FRAME_BITS-1];
               ss_d    = 1'b0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               bit_d   = 4'd0;
               high_d  = 1'b0;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               state_d = ST_SHIFT;
               sclk_d  = 1'b1;
               high_d  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (high_q) begin
                  // Last high-phase cycle: sample, then present the next bit as SCLK falls.
                  rx_d   = {rx_q[6:0], miso_q};
                  sclk_d = 1'b0;
                  high_d = 1'b0;
                  tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                  mosi_d = tx_q[FRAME_BITS-2];
               end else if (bit_q == 4'd15) begin
                  state_d = ST_HOLD;
               end else begin
                  bit_d  = bit_q + 4'd1;
                  sclk_d = 1'b1;
                  high_d = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_d     = ST_GAP;
               ss_d        = 1'b1;
               mosi_d      = 1'b0;
               rsp_valid_d = 1'b1;
               rdata_d     = rx_q;
            end
         end
         ST_GAP: begin
            if (tick) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_q       <= '0;
         high_q      <= 1'b0;
         sclk_q      <= 1'b0;
         ss_q        <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_q       <= bit_d;
         high_q      <= high_d;
         sclk_q      <= sclk_d;
         ss_q        <= ss_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         miso_q      <= spi_miso;
      end
   end

   assign cmd_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign busy      = busy_q;
   assign spi_sclk  = sclk_q;
   assign spi_mosi  = mosi_q;
   assign spi_ss    = ss_q;

endmodule
